// File: rtl/clock_pkg.sv
// Shared clock-domain types and constants: digit indices, BCD digit type,
// converter state encoding and the shift-add multiply helpers.
package clock_pkg;

   localparam int SECONDS_PER_DAY = 86400;

   localparam int DIG_S0 = 0;
   localparam int DIG_S1 = 1;
   localparam int DIG_M0 = 2;
   localparam int DIG_M1 = 3;
   localparam int DIG_H0 = 4;
   localparam int DIG_H1 = 5;

   localparam int ACC_W  = 19;

   typedef logic [3:0] bcd_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_CALC   = 2'd1,
      ST_FINISH = 2'd2
   } state_t;

   function automatic logic [ACC_W-1:0] mul10(input logic [ACC_W-1:0] a);
      return (a << 3) + (a << 1);
   endfunction

   function automatic logic [ACC_W-1:0] mul6(input logic [ACC_W-1:0] a);
      return (a << 2) + (a << 1);
   endfunction

endpackage

// File: rtl/bcd_digit_check.sv
// Combinational legality check over six captured HH:MM:SS BCD digits.
// Only instantiated when BCD_RANGE_CHECK_EN is defined.
module bcd_digit_check
   import clock_pkg::*;
#(
   parameter int p_hours_max = 23
)
(
   input  bcd_t dig_i [5:0],
   output logic bad_o
);

   logic [7:0] hours;

   always_comb begin
      bad_o = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (dig_i[i] > 4'd9) bad_o = 1'b1;
      end
      if (dig_i[DIG_M1] > 4'd5 || dig_i[DIG_S1] > 4'd5) bad_o = 1'b1;
      hours = ({4'd0, dig_i[DIG_H1]} << 3) + ({4'd0, dig_i[DIG_H1]} << 1)
            + {4'd0, dig_i[DIG_H0]};
      if ({24'd0, hours} > 32'(p_hours_max)) bad_o = 1'b1;
   end

endmodule

// File: rtl/bcd_to_seconds.sv
// HH:MM:SS BCD digits to seconds-of-day via a 5-step mixed-radix Horner loop.
// Define BCD_RANGE_CHECK_EN to flag illegal digit patterns on error.
//
//   state     | meaning
//   ST_IDLE   | waiting for start; digits captured when it arrives
//   ST_CALC   | one Horner step per cycle, steps 0..4
//   ST_FINISH | publish result (or error) with a one-cycle done pulse
module bcd_to_seconds
   import clock_pkg::*;
#(
   parameter int p_width     = 17,
   parameter int p_hours_max = 23
)
(
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  bcd_t               num [5:0],
   output logic               busy,
   output logic               done,
   output logic [p_width-1:0] seconds,
   output logic               error
);

   localparam logic [2:0] LAST_STEP = 3'd4;

   if (p_width < 17 || p_hours_max < 0 || p_hours_max > 99) begin : g_bad_param
      $error("bcd_to_seconds: p_width must be >= 17 and p_hours_max in 0..99");
   end

   state_t             state_q, state_d;
   logic [2:0]         step_q;
   logic [ACC_W-1:0]   acc_q, acc_d;
   bcd_t               dig_q [5:0];
   bcd_t               step_dig;
   logic [p_width-1:0] seconds_q;
   logic               error_q;
   logic               done_q;
   logic               illegal_q;
   logic               digits_bad;

`ifdef BCD_RANGE_CHECK_EN
   bcd_digit_check #(.p_hours_max(p_hours_max)) u_check (
      .dig_i (dig_q),
      .bad_o (digits_bad)
   );
`else
   assign digits_bad = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!reset) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (start) state_d = ST_CALC;
         ST_CALC:   if (step_q == LAST_STEP) state_d = ST_FINISH;
         ST_FINISH: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      busy = (state_q != ST_IDLE);
   end

   // Even steps scale by 10 (digit tens->units), odd steps by 6 (units->next tens).
   always_comb begin
      case (step_q)
         3'd0:    step_dig = dig_q[DIG_H0];
         3'd1:    step_dig = dig_q[DIG_M1];
         3'd2:    step_dig = dig_q[DIG_M0];
         3'd3:    step_dig = dig_q[DIG_S1];
         default: step_dig = dig_q[DIG_S0];
      endcase
      acc_d = (step_q[0] ? mul6(acc_q) : mul10(acc_q)) + ACC_W'(step_dig);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         step_q    <= 3'd0;
         acc_q     <= '0;
         dig_q     <= '{default: '0};
         seconds_q <= '0;
         error_q   <= 1'b0;
         done_q    <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  dig_q  <= num;
                  acc_q  <= ACC_W'(num[DIG_H1]);
                  step_q <= 3'd0;
               end
            end
            ST_CALC: begin
               acc_q  <= acc_d;
               step_q <= step_q + 3'd1;
               if (step_q == 3'd0) illegal_q <= digits_bad;
            end
            ST_FINISH: begin
               done_q  <= 1'b1;
               error_q <= illegal_q;
               if (!illegal_q) seconds_q <= p_width'(acc_q);
            end
            default: ;
         endcase
      end
   end

   assign done    = done_q;
   assign seconds = seconds_q;
   assign error   = error_q;

endmodule

// File: tb/tb_bcd_to_seconds.sv
// Scoreboard bench for bcd_to_seconds; range-check cases run when
// BCD_RANGE_CHECK_EN is defined, the wrap case otherwise.
module tb_bcd_to_seconds;
   import clock_pkg::*;

   localparam int W = 17;

   typedef struct {
      logic [W-1:0] sec;
      logic         err;
      int           due;
   } exp_t;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   bcd_t         num [5:0];
   logic         busy;
   logic         done;
   logic [W-1:0] seconds;
   logic         error;

   exp_t         exp_q[$];
   exp_t         mon_e;
   logic [W-1:0] last_good = '0;
   int           cyc = 0;
   int           done_cnt = 0;
   int           n_chk = 0;
   int           n_pass = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   bcd_to_seconds #(.p_width(W), .p_hours_max(23)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .num     (num),
      .busy    (busy),
      .done    (done),
      .seconds (seconds),
      .error   (error)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   function automatic logic [W-1:0] model_sec(input int h1, h0, m1, m0, s1, s0);
      longint t;
      t = longint'((h1 * 10 + h0) * 3600 + (m1 * 10 + m0) * 60 + s1 * 10 + s0);
      return t[W-1:0];
   endfunction

   function automatic logic model_bad(input int h1, h0, m1, m0, s1, s0);
`ifdef BCD_RANGE_CHECK_EN
      return (h1 > 9 || h0 > 9 || m1 > 5 || m0 > 9 || s1 > 5 || s0 > 9 ||
              (h1 * 10 + h0) > 23);
`else
      return 1'b0;
`endif
   endfunction

   task automatic set_num(input int h1, h0, m1, m0, s1, s0);
      num[5] = bcd_t'(h1); num[4] = bcd_t'(h0);
      num[3] = bcd_t'(m1); num[2] = bcd_t'(m0);
      num[1] = bcd_t'(s1); num[0] = bcd_t'(s0);
   endtask

   // Called at a falling edge with the DUT idle; returns at the falling edge after E0.
   task automatic send(input int h1, h0, m1, m0, s1, s0);
      exp_t e;
      e.err = model_bad(h1, h0, m1, m0, s1, s0);
      e.sec = e.err ? last_good : model_sec(h1, h0, m1, m0, s1, s0);
      e.due = cyc + 7;
      last_good = e.sec;
      exp_q.push_back(e);
      set_num(h1, h0, m1, m0, s1, s0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_start", busy, 1);
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("drain_timeout", exp_q.size(), 0);
   endtask

   task automatic wait_done();
      int n = 0;
      while (!done && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("done_seen", done, 1);
   endtask

   always @(negedge clk) begin
      if (reset && done) begin
         done_cnt++;
         if (exp_q.size() == 0) chk("done_unexpected", exp_q.size(), 1);
         else begin
            mon_e = exp_q.pop_front();
            chk("seconds", seconds, mon_e.sec);
            chk("error", error, mon_e.err);
            chk("latency", cyc, mon_e.due);
            chk("busy_at_done", busy, 0);
         end
      end
   end

   initial begin
      int base;
      int h, m, s;
      reset = 1'b0;
      start = 1'b0;
      set_num(0, 0, 0, 0, 0, 0);
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_seconds", seconds, 0);
      chk("rst_error", error, 0);
      reset = 1'b1;
      @(negedge clk);

      send(1, 3, 0, 3, 4, 0);
      drain();

      send(2, 3, 5, 9, 5, 9);
      wait_done();
      send(0, 0, 0, 0, 0, 0);
      drain();

      send(1, 3, 0, 3, 4, 0);
      @(negedge clk);
      set_num(0, 0, 0, 0, 0, 0);
      drain();

      base = done_cnt;
      send(1, 2, 3, 4, 5, 6);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      drain();
      repeat (10) @(negedge clk);
      chk("single_done", done_cnt - base, 1);

`ifdef BCD_RANGE_CHECK_EN
      send(2, 4, 0, 0, 0, 0);
      drain();
      send(0, 0, 0, 0, 0, 10);
      drain();
      send(0, 0, 6, 0, 0, 0);
      drain();
      send(0, 0, 0, 0, 0, 1);
      drain();
`else
      send(9, 9, 9, 9, 9, 9);
      drain();
`endif

      send(0, 1, 0, 0, 0, 1);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("midrst_busy", busy, 0);
      chk("midrst_done", done, 0);
      chk("midrst_seconds", seconds, 0);
      chk("midrst_error", error, 0);
      exp_q.delete();
      last_good = '0;
      reset = 1'b1;
      base = done_cnt;
      repeat (8) @(negedge clk);
      chk("midrst_no_done", done_cnt - base, 0);
      send(1, 0, 1, 0, 1, 0);
      drain();

      for (int i = 0; i < 5; i++) begin
         h = $urandom_range(0, 23);
         m = $urandom_range(0, 59);
         s = $urandom_range(0, 59);
         send(h / 10, h % 10, m / 10, m % 10, s / 10, s % 10);
         drain();
      end

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
